// File: rtl/iob_i2s_tx_ser_if.sv
// Stereo sample handshake plus the I2S serial lines of the transmitter.
// master = sample producer / line observer, slave = the serializer.
interface iob_i2s_tx_ser_if #(
    parameter int DATA_W = 16
) ();
    logic                  sample_valid;
    logic [2*DATA_W-1:0]   sample_data;
    logic                  sample_ready;
    logic                  bclk;
    logic                  lrclk;
    logic                  sdata;
    logic                  underflow;

    modport master (
        output sample_valid,
        output sample_data,
        input  sample_ready,
        input  bclk,
        input  lrclk,
        input  sdata,
        input  underflow
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        output sample_ready,
        output bclk,
        output lrclk,
        output sdata,
        output underflow
    );
endinterface

// File: rtl/iob_i2s_tx_ser.sv
// I2S master transmitter: one-entry holding register feeding a 2*DATA_W-bit frame serializer.
// All outputs registered; sample_ready drops while the holding register is full until the next frame load.
module iob_i2s_tx_ser #(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] bclk_div,
    iob_i2s_tx_ser_if.slave  bus
);
    localparam int FRAME_W = 2 * DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_RIGHT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(1);

    logic [DIV_W-1:0]   div_q,       div_d;
    logic               bclk_q,      bclk_d;
    logic               lrclk_q,     lrclk_d;
    logic               sdata_q,     sdata_d;
    logic               underflow_q, underflow_d;
    logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [FRAME_W-1:0] shift_q,     shift_d;
    logic [FRAME_W-1:0] hold_q,      hold_d;
    logic               hold_full_q, hold_full_d;

    logic [DIV_W-1:0]   div_last;
    logic               div_wrap;
    logic               fall_evt;
    logic               load_evt;
    logic               xfer;
    logic [CNT_W-1:0]   cnt_inc;

    // A divider value of 0 behaves as 1, so the last count is clamped at 0.
    assign div_last = (bclk_div == '0) ? '0 : bclk_div - DIV_W'(1);

    // Using >= lets a shrunken divisor restart at once instead of wrapping the counter.
    assign div_wrap = (div_q >= div_last);
    assign fall_evt = en && div_wrap && bclk_q;
    assign cnt_inc  = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
    assign load_evt = fall_evt && (cnt_inc == CNT_LOAD);
    assign xfer     = bus.sample_valid && !hold_full_q;

    always_comb begin
        div_d       = div_q;
        bclk_d      = bclk_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        underflow_d = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        if (!en) begin
            div_d     = '0;
            bclk_d    = 1'b0;
            lrclk_d   = 1'b1;
            sdata_d   = 1'b0;
            bit_cnt_d = CNT_LAST;
            shift_d   = '0;
        end else begin
            if (div_wrap) begin
                div_d  = '0;
                bclk_d = !bclk_q;
            end else begin
                div_d  = div_q + DIV_W'(1);
            end

            if (fall_evt) begin
                bit_cnt_d = cnt_inc;
                if (cnt_inc == '0) begin
                    lrclk_d = 1'b0;
                end else if (cnt_inc == CNT_RIGHT) begin
                    lrclk_d = 1'b1;
                end

                // The load decision uses the registered fill state, so a same-cycle transfer waits a frame.
                if (load_evt) begin
                    if (hold_full_q) begin
                        sdata_d     = hold_q[FRAME_W-1];
                        shift_d     = {hold_q[FRAME_W-2:0], 1'b0};
                        hold_full_d = 1'b0;
                    end else begin
                        sdata_d     = 1'b0;
                        shift_d     = '0;
                        underflow_d = 1'b1;
                    end
                end else begin
                    sdata_d = shift_q[FRAME_W-1];
                    shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                end
            end
        end

        // The holding register keeps accepting while the serializer is disabled.
        if (xfer) begin
            hold_d      = bus.sample_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= '0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b1;
            sdata_q     <= 1'b0;
            underflow_q <= 1'b0;
            bit_cnt_q   <= CNT_LAST;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            underflow_q <= underflow_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign bus.sample_ready = !hold_full_q;
    assign bus.bclk         = bclk_q;
    assign bus.lrclk        = lrclk_q;
    assign bus.sdata        = sdata_q;
    assign bus.underflow    = underflow_q;
endmodule
